// File: rtl/quad_step_pkg.sv
// Shared phase-state encodings and transition classification for the quadrature decoder.
package quad_step_pkg;

   localparam logic [1:0] PH_00 = 2'b00;
   localparam logic [1:0] PH_01 = 2'b01;
   localparam logic [1:0] PH_11 = 2'b11;
   localparam logic [1:0] PH_10 = 2'b10;

   localparam int DEFAULT_CNT_W = 3;

   typedef enum logic [1:0] {
      TR_NONE    = 2'd0,
      TR_UP      = 2'd1,
      TR_DOWN    = 2'd2,
      TR_ILLEGAL = 2'd3
   } trans_e;

   // Forward order is 00->01->11->10->00; any single-bit move that is not forward is reverse.
   function automatic trans_e classify_trans(input logic [1:0] prev, input logic [1:0] cur);
      logic [1:0] fwd_next;
      trans_e     t;
      case (prev)
         PH_00:   fwd_next = PH_01;
         PH_01:   fwd_next = PH_11;
         PH_11:   fwd_next = PH_10;
         default: fwd_next = PH_00;
      endcase
      if (prev == cur)
         t = TR_NONE;
      else if ((prev ^ cur) == 2'b11)
         t = TR_ILLEGAL;
      else if (cur == fwd_next)
         t = TR_UP;
      else
         t = TR_DOWN;
      return t;
   endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Synchronizes the raw phase pair into clk and only passes a new 2-bit state once it has
// been stable for FILT_CYCLES consecutive samples.
module quad_input_filter #(
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] raw,
   output logic [1:0] filt
);
   import quad_step_pkg::*;

   localparam int FCNT_W = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;

   logic [1:0]        r_sync [SYNC_STAGES];
   logic [1:0]        r_filt;
   logic [FCNT_W-1:0] r_fcnt;
   logic [1:0]        w_sync;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign filt   = r_filt;

   // NOTE: the synchronizer flops are reset too, so a phase pin held high at release is seen
   // as a fresh transition away from 00 rather than as an undefined start state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= PH_00;
      end else begin
         r_sync[0] <= raw;
         for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt <= PH_00;
         r_fcnt <= '0;
      end else if (w_sync == r_filt) begin
         r_fcnt <= '0;
      end else if (r_fcnt == FCNT_W'(FILT_CYCLES - 1)) begin
         r_filt <= w_sync;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + FCNT_W'(1);
      end
   end

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature receiver: filtered phase pair in, registered step/dir/pos/err out.
module quad_step_decoder
   import quad_step_pkg::*;
#(
   parameter int CNT_W       = DEFAULT_CNT_W,
   parameter int SYNC_STAGES = 2,
   parameter int FILT_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_in,
   input  logic             b_in,
   input  logic             clr_pos,
   input  logic             clr_err,
   output logic             step,
   output logic             dir,
   output logic [CNT_W-1:0] pos,
   output logic             err,
   output logic             err_sticky
);

   logic [1:0]       w_filt;
   trans_e           w_trans;
   logic [1:0]       r_filt_prev;
   logic             r_step;
   logic             r_dir;
   logic [CNT_W-1:0] r_pos;
   logic             r_err;
   logic             r_err_sticky;

   quad_input_filter #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
   ) u_filter (
      .clk (clk),
      .rst (rst),
      .raw ({a_in, b_in}),
      .filt(w_filt)
   );

   assign w_trans = classify_trans(r_filt_prev, w_filt);

   // NOTE: every piece of decoder state is assigned with <= so all of it samples the same
   // pre-edge filt/filt_prev pair, regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_filt_prev  <= PH_00;
         r_step       <= 1'b0;
         r_dir        <= 1'b1;
         r_pos        <= '0;
         r_err        <= 1'b0;
         r_err_sticky <= 1'b0;
      end else begin
         r_filt_prev <= w_filt;
         r_step      <= (w_trans == TR_UP) || (w_trans == TR_DOWN);
         r_err       <= (w_trans == TR_ILLEGAL);

         if (w_trans == TR_UP)
            r_dir <= 1'b1;
         else if (w_trans == TR_DOWN)
            r_dir <= 1'b0;

         // Clear beats a coincident step; step/dir above still report the motion.
         if (clr_pos)
            r_pos <= '0;
         else if (w_trans == TR_UP)
            r_pos <= r_pos + CNT_W'(1);
         else if (w_trans == TR_DOWN)
            r_pos <= r_pos - CNT_W'(1);

         if (clr_err)
            r_err_sticky <= 1'b0;
         else if (w_trans == TR_ILLEGAL)
            r_err_sticky <= 1'b1;
      end
   end

   assign step       = r_step;
   assign dir        = r_dir;
   assign pos        = r_pos;
   assign err        = r_err;
   assign err_sticky = r_err_sticky;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder: a vector table plus hand-written glitch and reset sequences.
module tb_quad_step_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       a_in, b_in, clr_pos, clr_err;
   logic       step, dir, err, err_sticky;
   logic [2:0] pos;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      string      name;
      logic       a, b, cp, ce;
      int         cycles;
      logic       e_step, e_dir;
      logic [2:0] e_pos;
      logic       e_err, e_sticky;
   } vec_t;

   vec_t vecs[$];

   quad_step_decoder #(.CNT_W(3), .SYNC_STAGES(2), .FILT_CYCLES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_in      (a_in),
      .b_in      (b_in),
      .clr_pos   (clr_pos),
      .clr_err   (clr_err),
      .step      (step),
      .dir       (dir),
      .pos       (pos),
      .err       (err),
      .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string name, input logic e_step, input logic e_dir,
                            input logic [2:0] e_pos, input logic e_err, input logic e_sticky);
      check({name, ".step"},   {31'd0, step},       {31'd0, e_step});
      check({name, ".dir"},    {31'd0, dir},        {31'd0, e_dir});
      check({name, ".pos"},    {29'd0, pos},        {29'd0, e_pos});
      check({name, ".err"},    {31'd0, err},        {31'd0, e_err});
      check({name, ".sticky"}, {31'd0, err_sticky}, {31'd0, e_sticky});
   endtask

   function automatic vec_t mk(input string n, input logic a, input logic b, input logic cp,
                               input logic ce, input int c, input logic s, input logic d,
                               input logic [2:0] p, input logic e, input logic st);
      vec_t v;
      v.name = n; v.a = a; v.b = b; v.cp = cp; v.ce = ce; v.cycles = c;
      v.e_step = s; v.e_dir = d; v.e_pos = p; v.e_err = e; v.e_sticky = st;
      return v;
   endfunction

   task automatic run_vectors(input int lo, input int hi);
      for (int i = lo; i < hi; i++) begin
         a_in = vecs[i].a; b_in = vecs[i].b; clr_pos = vecs[i].cp; clr_err = vecs[i].ce;
         cycles(vecs[i].cycles);
         check_all(vecs[i].name, vecs[i].e_step, vecs[i].e_dir, vecs[i].e_pos,
                   vecs[i].e_err, vecs[i].e_sticky);
      end
   endtask

   int split;

   initial begin
      //                  name          a  b  cp ce cyc step dir pos err st
      // Forward walk: step appears exactly 5 edges after each input change.
      vecs.push_back(mk("fwd01_pre",  0, 1, 0, 0, 4, 0, 1, 3'd0, 0, 0));
      vecs.push_back(mk("fwd01_step", 0, 1, 0, 0, 1, 1, 1, 3'd1, 0, 0));
      vecs.push_back(mk("fwd01_post", 0, 1, 0, 0, 1, 0, 1, 3'd1, 0, 0));
      vecs.push_back(mk("fwd11_pre",  1, 1, 0, 0, 4, 0, 1, 3'd1, 0, 0));
      vecs.push_back(mk("fwd11_step", 1, 1, 0, 0, 1, 1, 1, 3'd2, 0, 0));
      vecs.push_back(mk("fwd11_post", 1, 1, 0, 0, 1, 0, 1, 3'd2, 0, 0));
      vecs.push_back(mk("fwd10_pre",  1, 0, 0, 0, 4, 0, 1, 3'd2, 0, 0));
      vecs.push_back(mk("fwd10_step", 1, 0, 0, 0, 1, 1, 1, 3'd3, 0, 0));
      vecs.push_back(mk("fwd10_post", 1, 0, 0, 0, 1, 0, 1, 3'd3, 0, 0));
      vecs.push_back(mk("fwd00_pre",  0, 0, 0, 0, 4, 0, 1, 3'd3, 0, 0));
      vecs.push_back(mk("fwd00_step", 0, 0, 0, 0, 1, 1, 1, 3'd4, 0, 0));
      vecs.push_back(mk("fwd00_post", 0, 0, 0, 0, 1, 0, 1, 3'd4, 0, 0));
      // Climb to 7, then wrap up to 0 and back down to 7.
      vecs.push_back(mk("to5",        0, 1, 0, 0, 6, 0, 1, 3'd5, 0, 0));
      vecs.push_back(mk("to6",        1, 1, 0, 0, 6, 0, 1, 3'd6, 0, 0));
      vecs.push_back(mk("to7",        1, 0, 0, 0, 6, 0, 1, 3'd7, 0, 0));
      vecs.push_back(mk("wrap_up",    0, 0, 0, 0, 5, 1, 1, 3'd0, 0, 0));
      vecs.push_back(mk("wrap_up_h",  0, 0, 0, 0, 1, 0, 1, 3'd0, 0, 0));
      vecs.push_back(mk("wrap_dn",    1, 0, 0, 0, 5, 1, 0, 3'd7, 0, 0));
      vecs.push_back(mk("wrap_dn_h",  1, 0, 0, 0, 1, 0, 0, 3'd7, 0, 0));
      vecs.push_back(mk("back_to0",   0, 0, 0, 0, 6, 0, 1, 3'd0, 0, 0));
      split = vecs.size();
      // Illegal jump 00->11, then clear the sticky flag.
      vecs.push_back(mk("ill_pulse",  1, 1, 0, 0, 5, 0, 1, 3'd0, 1, 1));
      vecs.push_back(mk("ill_after",  1, 1, 0, 0, 1, 0, 1, 3'd0, 0, 1));
      vecs.push_back(mk("clr_err",    1, 1, 0, 1, 1, 0, 1, 3'd0, 0, 0));
      // Walk to pos 3, then clear pos on the very edge of the next forward step.
      vecs.push_back(mk("cp_to1",     1, 0, 0, 0, 6, 0, 1, 3'd1, 0, 0));
      vecs.push_back(mk("cp_to2",     0, 0, 0, 0, 6, 0, 1, 3'd2, 0, 0));
      vecs.push_back(mk("cp_to3",     0, 1, 0, 0, 6, 0, 1, 3'd3, 0, 0));
      vecs.push_back(mk("cp_pre",     1, 1, 0, 0, 4, 0, 1, 3'd3, 0, 0));
      vecs.push_back(mk("cp_hit",     1, 1, 1, 0, 1, 1, 1, 3'd0, 0, 0));
      vecs.push_back(mk("cp_post",    1, 1, 0, 0, 1, 0, 1, 3'd0, 0, 0));
      // Leave dir=0 and err_sticky=1 so the async reset has something to clear.
      vecs.push_back(mk("rev_to7",    0, 1, 0, 0, 6, 0, 0, 3'd7, 0, 0));
      vecs.push_back(mk("ill_01_10",  1, 0, 0, 0, 6, 0, 0, 3'd7, 0, 1));

      rst = 1'b1; a_in = 1'b0; b_in = 1'b0; clr_pos = 1'b0; clr_err = 1'b0;
      cycles(3);
      check_all("reset_hold", 0, 1, 3'd0, 0, 0);
      rst = 1'b0;

      run_vectors(0, split);

      // One-clock pulse on a_in must be filtered out entirely.
      a_in = 1'b1;
      cycles(1);
      a_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycles(1);
         check({"glitch.step"}, {31'd0, step}, 32'd0);
         check({"glitch.err"},  {31'd0, err},  32'd0);
      end
      check("glitch.pos", {29'd0, pos}, 32'd0);

      run_vectors(split, vecs.size());

      // Async reset between edges with phases at 10, then release: one reverse step from 00.
      #3 rst = 1'b1;
      #1;
      check_all("async_rst", 0, 1, 3'd0, 0, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      cycles(4);
      check_all("post_rst_pre", 0, 1, 3'd0, 0, 0);
      cycles(1);
      check_all("post_rst_step", 1, 0, 3'd7, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
